// File: rtl/reset_button_debounce.sv
// Synchronizes and debounces the active-low reset pushbutton.
// Define RESET_DEBOUNCE_GLITCH_CNT_EN to add the saturating Glitch_Count output.
module reset_button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Btn_Raw,
    output logic       Reset_L,
    output logic       Press_Pulse,
    output logic       Release_Pulse,
    output logic       Busy
`ifdef RESET_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] Glitch_Count
`endif
);

    typedef enum logic [1:0] {
        REL,
        CONF_LO,
        HELD,
        CONF_HI
    } state_t;

    localparam logic [15:0] ACCEPT_CNT = 16'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    state_t                 state_q;
    state_t                 state_d;
    logic [15:0]            cnt_q;
    logic [15:0]            cnt_d;
    logic                   reset_l_d;
    logic                   press_d;
    logic                   release_d;

    // Flops preset to 1 so a reset never looks like a press.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Btn_Raw};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= REL;
            cnt_q         <= '0;
            Reset_L       <= 1'b1;
            Press_Pulse   <= 1'b0;
            Release_Pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            Reset_L       <= reset_l_d;
            Press_Pulse   <= press_d;
            Release_Pulse <= release_d;
        end
    end

    // cnt counts samples already seen at the new level, so acceptance
    // happens on sample DEBOUNCE_CYCLES+1 and cnt never passes ACCEPT_CNT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reset_l_d = Reset_L;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            REL: begin
                if (!sync_out) begin
                    state_d = CONF_LO;
                    cnt_d   = 16'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            CONF_LO: begin
                if (sync_out) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == ACCEPT_CNT) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    reset_l_d = 1'b0;
                    press_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HELD: begin
                if (sync_out) begin
                    state_d = CONF_HI;
                    cnt_d   = 16'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            CONF_HI: begin
                if (!sync_out) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == ACCEPT_CNT) begin
                    state_d   = REL;
                    cnt_d     = '0;
                    reset_l_d = 1'b1;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    assign Busy = (state_q == CONF_LO) || (state_q == CONF_HI);

`ifdef RESET_DEBOUNCE_GLITCH_CNT_EN
    logic abort;

    assign abort = ((state_q == CONF_LO) && sync_out) ||
                   ((state_q == CONF_HI) && !sync_out);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Glitch_Count <= '0;
        end else if (abort && (Glitch_Count != 8'hFF)) begin
            Glitch_Count <= Glitch_Count + 8'd1;
        end
    end
`endif

endmodule
